// File: rtl/servo_uart_if.sv
// Byte-level handshake between the servo command sequencer and a UART
// transmitter: the sequencer offers a byte with a one-cycle uart_en pulse and
// the transmitter answers with a one-cycle trans_done pulse once it is sent.
interface servo_uart_if;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       trans_done;

  // Sequencer side: drives the byte, listens for completion.
  modport master (
    output uart_en,
    output uart_din,
    input  trans_done
  );

  // UART transmitter side.
  modport slave (
    input  uart_en,
    input  uart_din,
    output trans_done
  );
endinterface

// File: rtl/servo_cmd_sequencer.sv
// Servo command sequencer: turns up to three configured servo slots into
// ASCII frames "#CCCPppppTtttt!" and feeds them byte by byte to a UART
// transmitter, with an optional idle gap after each frame and optional
// looping over the whole slot list.
module servo_cmd_sequencer #(
  parameter int unsigned GAP_CYCLES = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [1:0]  cmd_count,
  input  logic [35:0] cfg_ch,
  input  logic [47:0] cfg_pw,
  input  logic [47:0] cfg_tm,
  servo_uart_if.master uart,
  output logic        busy,
  output logic        done,
  output logic [3:0]  led
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND    = 3'd1;
  localparam logic [2:0] WAIT_TX = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  localparam logic [3:0] LAST_BYTE = 4'd14;

  // Final value of the gap counter; a zero-length gap still spends one cycle
  // in GAP so the exit decision has a state to live in.
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_T    = 8'h54;
  localparam logic [7:0] ASCII_BANG = 8'h21;

  logic [2:0]  state_q,    state_d;
  logic [35:0] ch_q,       ch_d;
  logic [47:0] pw_q,       pw_d;
  logic [47:0] tm_q,       tm_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic [1:0]  cmd_idx_q,  cmd_idx_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic        stop_q,     stop_d;
  logic [31:0] gap_cnt_q,  gap_cnt_d;
  logic        uart_en_q,  uart_en_d;
  logic [7:0]  uart_din_q, uart_din_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [3:0]  led_q,      led_d;

  logic [11:0] slot_ch;
  logic [15:0] slot_pw;
  logic [15:0] slot_tm;
  logic [7:0]  tx_byte;
  logic        stop_hit;

  // Out-of-range BCD digits are clamped to '9' rather than sent as garbage.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] digit);
    return (digit > 4'd9) ? 8'h39 : {4'h3, digit};
  endfunction

  // Pick the active slot's fields and the ASCII byte at the current position.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave it unassigned and infer a latch.
    slot_ch = ch_q[11:0];
    slot_pw = pw_q[15:0];
    slot_tm = tm_q[15:0];
    tx_byte = ASCII_BANG;
    case (cmd_idx_q)
      2'd1: begin
        slot_ch = ch_q[23:12];
        slot_pw = pw_q[31:16];
        slot_tm = tm_q[31:16];
      end
      2'd2: begin
        slot_ch = ch_q[35:24];
        slot_pw = pw_q[47:32];
        slot_tm = tm_q[47:32];
      end
      default: ;
    endcase
    case (byte_idx_q)
      4'd0:    tx_byte = ASCII_HASH;
      4'd1:    tx_byte = bcd_ascii(slot_ch[11:8]);
      4'd2:    tx_byte = bcd_ascii(slot_ch[7:4]);
      4'd3:    tx_byte = bcd_ascii(slot_ch[3:0]);
      4'd4:    tx_byte = ASCII_P;
      4'd5:    tx_byte = bcd_ascii(slot_pw[15:12]);
      4'd6:    tx_byte = bcd_ascii(slot_pw[11:8]);
      4'd7:    tx_byte = bcd_ascii(slot_pw[7:4]);
      4'd8:    tx_byte = bcd_ascii(slot_pw[3:0]);
      4'd9:    tx_byte = ASCII_T;
      4'd10:   tx_byte = bcd_ascii(slot_tm[15:12]);
      4'd11:   tx_byte = bcd_ascii(slot_tm[11:8]);
      4'd12:   tx_byte = bcd_ascii(slot_tm[7:4]);
      4'd13:   tx_byte = bcd_ascii(slot_tm[3:0]);
      default: tx_byte = ASCII_BANG;
    endcase
  end

  // A stop request counts whether it arrived earlier or is arriving now.
  assign stop_hit = stop_q | stop;

  // Sequencer next-state logic and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    pw_d       = pw_q;
    tm_d       = tm_q;
    last_idx_d = last_idx_q;
    cmd_idx_d  = cmd_idx_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    uart_en_d  = 1'b0;
    uart_din_d = uart_din_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          ch_d       = cfg_ch;
          pw_d       = cfg_pw;
          tm_d       = cfg_tm;
          last_idx_d = (cmd_count == 2'd0) ? 2'd0 : cmd_count - 2'd1;
          cmd_idx_d  = 2'd0;
          byte_idx_d = 4'd0;
          state_d    = SEND;
        end
      end

      SEND: begin
        uart_en_d  = 1'b1;
        uart_din_d = tx_byte;
        state_d    = WAIT_TX;
      end

      WAIT_TX: begin
        if (uart.trans_done) begin
          if (stop_hit) begin
            state_d = IDLE;
          end else if (byte_idx_q == LAST_BYTE) begin
            gap_cnt_d = 32'd0;
            state_d   = GAP;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = SEND;
          end
        end
      end

      GAP: begin
        if (stop_hit) begin
          state_d = IDLE;
        end else if (gap_cnt_q >= GAP_LAST) begin
          if (cmd_idx_q < last_idx_q) begin
            cmd_idx_d  = cmd_idx_q + 2'd1;
            byte_idx_d = 4'd0;
            state_d    = SEND;
          end else begin
            state_d = FINISH;
          end
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end

      FINISH: begin
        if (stop_hit) begin
          state_d = IDLE;
        end else if (loop_en) begin
          ch_d       = cfg_ch;
          pw_d       = cfg_pw;
          tm_d       = cfg_tm;
          last_idx_d = (cmd_count == 2'd0) ? 2'd0 : cmd_count - 2'd1;
          cmd_idx_d  = 2'd0;
          byte_idx_d = 4'd0;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    stop_d = (state_d == IDLE) ? 1'b0 : stop_hit;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
    led_d  = {busy_d, busy_d & loop_en, cmd_idx_d};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      pw_q       <= '0;
      tm_q       <= '0;
      last_idx_q <= '0;
      cmd_idx_q  <= '0;
      byte_idx_q <= '0;
      stop_q     <= 1'b0;
      gap_cnt_q  <= '0;
      uart_en_q  <= 1'b0;
      uart_din_q <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pw_q       <= pw_d;
      tm_q       <= tm_d;
      last_idx_q <= last_idx_d;
      cmd_idx_q  <= cmd_idx_d;
      byte_idx_q <= byte_idx_d;
      stop_q     <= stop_d;
      gap_cnt_q  <= gap_cnt_d;
      uart_en_q  <= uart_en_d;
      uart_din_q <= uart_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign uart.uart_en  = uart_en_q;
  assign uart.uart_din = uart_din_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign led           = led_q;

endmodule

// File: doc/servo_cmd_sequencer.md
SERVO_CMD_SEQUENCER -- requirements
Module: servo_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 50_000_000, meaning idle clock cycles inserted after each command (0 = no gap).
REQ-002 The block SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port sys_rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port start  input  1  level sampled in IDLE; begins a sequence.
REQ-005 The block SHALL have port stop  input  1  request to end the sequence after the in-flight byte.
REQ-006 The block SHALL have port loop_en  input  1  restart from slot 0 after the last slot.
REQ-007 The block SHALL have port cmd_count  input  2  number of slots to send, 1..3; 0 treated as 1.
REQ-008 The block SHALL have port cfg_ch  input  36  slot k channel, 3 BCD digits at [12k+11:12k], MSD first.
REQ-009 The block SHALL have port cfg_pw  input  48  slot k pulse width, 4 BCD digits at [16k+15:16k].
REQ-010 The block SHALL have port cfg_tm  input  48  slot k move time, 4 BCD digits at [16k+15:16k].
REQ-011 The block SHALL have port trans_done  input  1  one-cycle pulse from UART TX: current byte finished.
REQ-012 The block SHALL have port uart_en  output  1  one-cycle pulse: transmit uart_din.
REQ-013 The block SHALL have port uart_din  output  8  ASCII byte to transmit; held stable until trans_done.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at normal sequence completion.
REQ-016 The block SHALL have port led  output  4  {busy, loop active, cmd_idx[1:0]}.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, WAIT_TX, GAP, FINISH; all outputs SHALL be registered.
REQ-018 In IDLE with start=1, the block SHALL snapshot cfg_ch/cfg_pw/cfg_tm/cmd_count, set cmd_idx=0, byte_idx=0, and go to SEND.
REQ-019 SEND SHALL last one cycle, assert uart_en=1 with uart_din = byte[byte_idx], then go to WAIT_TX.
REQ-020 The 15-byte frame SHALL be: 0 '#', 1-3 channel digits, 4 'P', 5-8 pulse digits, 9 'T', 10-13 time digits, 14 '!'; digits sent MSD first as 8'h30+digit.
REQ-021 Any BCD digit greater than 9 SHALL be transmitted as '9' (8'h39).
REQ-022 In WAIT_TX, trans_done=1 with byte_idx<14 SHALL increment byte_idx and return to SEND (next uart_en exactly 2 cycles after the trans_done cycle).
REQ-023 In WAIT_TX, trans_done=1 with byte_idx=14 SHALL go to GAP with gap counter cleared; if GAP_CYCLES=0 GAP lasts one cycle.
REQ-024 GAP SHALL last GAP_CYCLES cycles; then if cmd_idx < cmd_count-1, cmd_idx increments, byte_idx=0, go to SEND; otherwise go to FINISH.
REQ-025 FINISH SHALL last one cycle with done=1; if loop_en=1 the block SHALL re-snapshot configuration, set cmd_idx=0, and go to SEND, else go to IDLE.
REQ-026 trans_done outside WAIT_TX SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-027 stop SHALL be latched while busy; at the next trans_done in WAIT_TX, or immediately in GAP or FINISH, the block SHALL return to IDLE with done=0.
REQ-028 stop and start asserted together in IDLE SHALL leave the block in IDLE.
REQ-029 The gap counter SHALL be 32 bits wide and SHALL not wrap.

Reset
REQ-030 While sys_rst_n=0 at a clock edge, the FSM SHALL enter IDLE and uart_en, busy, done, led, cmd_idx, byte_idx, the stop latch and the gap counter SHALL be 0; uart_din SHALL be 8'h00.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further uart_en pulses.

Verification
REQ-032 cmd_count=1, slot0 ch=000 pw=1500 tm=1000, GAP_CYCLES=4, trans_done 10 cycles after each uart_en -> bytes "#000P1500T1000!" in order, done pulse 1 cycle, busy low afterwards.
REQ-033 cmd_count=3, slots 000/1500/1000, 001/2500/1000, 002/3500/1400 -> three frames in slot order, led[1:0] = 0,1,2, exactly 4 idle cycles between frames.
REQ-034 Slot0 pw=16'h15A0 -> frame contains "P1590".
REQ-035 stop pulsed during byte 5 -> byte 5 completes, no uart_en afterwards, done stays 0, busy falls.
REQ-036 loop_en=1, cmd_count=1 -> done pulses, then frame repeats; sys_rst_n=0 mid-frame -> all outputs 0 on the next edge.
